// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback register file: datapath width,
// register count, register-index type and branch-condition encodings.
// Latency: n/a (declarations only). Backpressure: n/a.
package wb_regfile_pkg;

  localparam int DW   = 8;  // datapath width, matches ALU a/b/t
  localparam int NREG = 4;  // general registers R0..R3

  typedef logic [1:0] reg_idx_t;

  // Branch test encodings on the cond input
  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_CF     = 2'b01;
  localparam logic [1:0] COND_ZF     = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

endpackage

// File: rtl/wb_flag_cond.sv
// Carry/zero flag register plus registered branch-condition evaluation.
// Latency: flags and take update one clock after their inputs. Backpressure: none.
// Ports: clk, rst_n; flag_en (qualified flag write), cf_in/zf_in; cond (branch test);
//        cf/zf (registered flags); take (registered decision from pre-update flags).
module wb_flag_cond (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_en,
  input  logic       cf_in,
  input  logic       zf_in,
  input  logic [1:0] cond,
  output logic       cf,
  output logic       zf,
  output logic       take
);
  import wb_regfile_pkg::*;

  logic take_nxt;

  // Evaluated against the flags as they stand before this edge, so a flag
  // update in the same cycle is only seen by the branch one cycle later.
  always_comb begin
    take_nxt = 1'b0;
    case (cond)
      COND_ALWAYS: take_nxt = 1'b1;
      COND_CF:     take_nxt = cf;
      COND_ZF:     take_nxt = zf;
      COND_NEVER:  take_nxt = 1'b0;
      default:     take_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf   <= 1'b0;
      zf   <= 1'b0;
      take <= 1'b0;
    end else begin
      take <= take_nxt;
      if (flag_en) begin
        cf <= cf_in;
        zf <= zf_in;
      end
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Four-entry ALU writeback register file with flags, branch decision and write counter.
// Latency: writes/flags/take/wb_cnt update at the next edge; reads are combinational.
// Backpressure: none, every wb_valid cycle is accepted.
// Ports: clk, rst_n; wb_valid/wb_we/wb_dst/wb_data (register write); flag_we/cf_in/zf_in
//        (flag write); ra_sel/rb_sel -> ra_data/rb_data; cond -> take; cf, zf; wb_cnt.
// Build option: define WB_BYPASS_EN to forward wb_data to a read port that selects
//        the register being written in the same cycle.
module wb_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  input  logic          wb_we,
  input  logic [1:0]    wb_dst,
  input  logic [DW-1:0] wb_data,
  input  logic          flag_we,
  input  logic          cf_in,
  input  logic          zf_in,
  input  logic [1:0]    ra_sel,
  input  logic [1:0]    rb_sel,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic          cf,
  output logic          zf,
  input  logic [1:0]    cond,
  output logic          take,
  output logic [7:0]    wb_cnt
);
  import wb_regfile_pkg::*;

  logic [DW-1:0] regs [NREG];
  logic          wr_acc;
  reg_idx_t      wr_idx;

  assign wr_acc = wb_valid & wb_we;
  assign wr_idx = wb_dst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wb_cnt <= 8'h00;
    end else if (wr_acc) begin
      regs[wr_idx] <= wb_data;
      wb_cnt       <= wb_cnt + 8'd1;  // wraps FF -> 00 naturally
    end
  end

`ifdef WB_BYPASS_EN
  // Forward the in-flight write so the ALU sees the new value without a stall.
  assign ra_data = (wr_acc && (ra_sel == wr_idx)) ? wb_data : regs[ra_sel];
  assign rb_data = (wr_acc && (rb_sel == wr_idx)) ? wb_data : regs[rb_sel];
`else
  assign ra_data = regs[ra_sel];
  assign rb_data = regs[rb_sel];
`endif

  wb_flag_cond u_flag_cond (
    .clk     (clk),
    .rst_n   (rst_n),
    .flag_en (wb_valid & flag_we),
    .cf_in   (cf_in),
    .zf_in   (zf_in),
    .cond    (cond),
    .cf      (cf),
    .zf      (zf),
    .take    (take)
  );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid, wb_we, flag_we, cf_in, zf_in;
  logic [1:0] wb_dst, ra_sel, rb_sel, cond;
  logic [7:0] wb_data;
  logic [7:0] ra_data, rb_data, wb_cnt;
  logic       cf, zf, take;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural state as plain integers
  int mreg [4];
  int mcf, mzf, mtake, mcnt;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_dst   (wb_dst),
    .wb_data  (wb_data),
    .flag_we  (flag_we),
    .cf_in    (cf_in),
    .zf_in    (zf_in),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .cf       (cf),
    .zf       (zf),
    .cond     (cond),
    .take     (take),
    .wb_cnt   (wb_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_read(input int sel);
    if (BYPASS && wb_valid && wb_we && (sel == int'(wb_dst))) return int'(wb_data);
    return mreg[sel];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 0;
    mcf = 0; mzf = 0; mtake = 0; mcnt = 0;
  endfunction

  task automatic drive(input bit v, input bit we, input int dst, input int data,
                       input bit fwe, input bit ci, input bit zi, input int cnd,
                       input int ras, input int rbs);
    wb_valid = v;  wb_we = we;  wb_dst = dst[1:0];  wb_data = data[7:0];
    flag_we  = fwe; cf_in = ci; zf_in = zi;  cond = cnd[1:0];
    ra_sel   = ras[1:0]; rb_sel = rbs[1:0];
  endtask

  // One clock: check combinational reads before the edge, advance the model,
  // then check every output just after the edge.
  task automatic cycle();
    int nt;
    #1;
    check("ra_pre", ra_data, exp_read(int'(ra_sel)));
    check("rb_pre", rb_data, exp_read(int'(rb_sel)));
    case (int'(cond))
      0: nt = 1;
      1: nt = mcf;
      2: nt = mzf;
      default: nt = 0;
    endcase
    @(posedge clk);
    #1;
    if (wb_valid && wb_we) begin
      mreg[int'(wb_dst)] = int'(wb_data);
      mcnt = (mcnt + 1) % 256;
    end
    if (wb_valid && flag_we) begin
      mcf = int'(cf_in);
      mzf = int'(zf_in);
    end
    mtake = nt;
    check("cf",     cf,     mcf);
    check("zf",     zf,     mzf);
    check("take",   take,   mtake);
    check("wb_cnt", wb_cnt, mcnt);
    check("ra_post", ra_data, exp_read(int'(ra_sel)));
    check("rb_post", rb_data, exp_read(int'(rb_sel)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ra"},   ra_data, 0);
    check({tag, "_rb"},   rb_data, 0);
    check({tag, "_cf"},   cf,      0);
    check({tag, "_zf"},   zf,      0);
    check({tag, "_take"}, take,    0);
    check({tag, "_cnt"},  wb_cnt,  0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
    model_reset();
    #3;
    check_all_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First edge after reset release accepts writes
    drive(1, 1, 2, 8'hA5, 0, 0, 0, 3, 2, 1); cycle();
    drive(1, 1, 1, 8'h3C, 0, 0, 0, 3, 2, 1); cycle();
    drive(0, 0, 0, 0,     0, 0, 0, 3, 2, 1); cycle();
    check("rd_r2", ra_data, 8'hA5);
    check("rd_r1", rb_data, 8'h3C);
    check("cnt2",  wb_cnt,  2);

    // Flags, then branch tests against them
    drive(1, 0, 0, 0, 1, 1, 0, 3, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
    check("take_cf", take, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 2, 0, 0); cycle();
    check("take_zf", take, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 0); cycle();
    check("take_never", take, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("take_always", take, 1);

    // Unqualified enables must be ignored
    drive(0, 1, 2, 8'hFF, 1, 0, 1, 3, 2, 1); cycle();
    check("qual_r2", ra_data, 8'hA5);
    check("qual_cf", cf, 1);
    check("qual_cnt", wb_cnt, 2);

    // Read during write of R0
    drive(1, 1, 0, 8'h11, 0, 0, 0, 3, 0, 2); cycle();
    drive(1, 1, 0, 8'h22, 0, 0, 0, 3, 0, 0);
    #1;
    check("rdw_pre", ra_data, BYPASS ? 8'h22 : 8'h11);
    cycle();
    check("rdw_post_a", ra_data, 8'h22);
    check("rdw_post_b", rb_data, 8'h22);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3));
      cycle();
    end

    // Reset mid-cycle while a write is being presented
    @(posedge clk); #1;
    drive(1, 1, 3, 8'h5A, 1, 1, 1, 0, 0, 1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("arst");
    #1 rst_n = 1'b1;
    cycle();
    check("post_rst_cnt", wb_cnt, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 3, 2, 3); cycle();
    check("post_rst_r2", ra_data, 0);
    check("post_rst_r3", rb_data, 8'h5A);

    // Counter wrap: 256 writes from reset, flag-only cycles interleaved
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
    for (int n = 0; n < 256; n++) begin
      drive(1, 1, $urandom_range(0, 3), $urandom_range(0, 255), 0, 0, 0, 3,
            $urandom_range(0, 3), $urandom_range(0, 3));
      cycle();
      if (n % 32 == 5) begin
        drive(1, 0, 0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 1);
        cycle();
      end
    end
    check("wrap_cnt", wb_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameters SHALL be: DW, 8, datapath width (matches ALU a/b/t); NREG, 4, general registers R0..R3 (fixed; index 2 bits).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 wb_valid  in  1  ALU result presented this cycle.
REQ-005 wb_we  in  1  write wb_data to register wb_dst (qualified by wb_valid).
REQ-006 wb_dst  in  2  destination register index.
REQ-007 wb_data  in  DW  ALU result t.
REQ-008 flag_we  in  1  latch cf_in/zf_in (qualified by wb_valid).
REQ-009 cf_in, zf_in  in  1 each  ALU carry/zero outputs.
REQ-010 ra_sel, rb_sel  in  2 each  read-port register indices.
REQ-011 ra_data, rb_data  out  DW each  operands to ALU a and b.
REQ-012 cf, zf  out  1 each  registered flags.
REQ-013 cond  in  2  branch test: 00 always, 01 CF set, 10 ZF set, 11 never.
REQ-014 take  out  1  registered branch decision.
REQ-015 wb_cnt  out  8  count of accepted register writes.

Function
REQ-016 A register write SHALL occur at the clock edge when wb_valid=1 and wb_we=1; target R[wb_dst] <= wb_data.
REQ-017 Flags SHALL update at the edge when wb_valid=1 and flag_we=1: cf<=cf_in, zf<=zf_in; otherwise hold.
REQ-018 Register write and flag update in the same cycle SHALL both take effect, independently.
REQ-019 wb_we or flag_we with wb_valid=0 SHALL be ignored (no state change).
REQ-020 Read ports SHALL be combinational from register contents: ra_data=R[ra_sel], rb_data=R[rb_sel]; both ports may select the same register.
REQ-021 Read of the register being written in the same cycle SHALL return per REQ-030/031.
REQ-022 take SHALL be registered each cycle from cond and current (pre-update) cf/zf: 00->1, 01->cf, 10->zf, 11->0; latency one cycle.
REQ-023 wb_cnt SHALL increment by 1 on each accepted register write (REQ-016) and wrap 8'hFF->8'h00; flag-only updates do not count.
REQ-024 No back-pressure: every wb_valid cycle SHALL be accepted.

Reset
REQ-025 On rst_n=0, asynchronously: R0..R3=0, cf=0, zf=0, take=0, wb_cnt=0.
REQ-026 Reset asserted mid-write SHALL win: the write is lost, all state reads zero.
REQ-027 First write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro WB_BYPASS_EN selects read-during-write behaviour.
REQ-029 Only the read ports are affected; all other behaviour identical.
REQ-030 Defined: if wb_valid=1, wb_we=1 and a read sel equals wb_dst, that port SHALL return wb_data in the same cycle.
REQ-031 Undefined: such a port SHALL return the old register value until the edge.

Structure
REQ-032 Shared package SHALL hold DW, NREG, the cond encodings (COND_ALWAYS, COND_CF, COND_ZF, COND_NEVER) and the register-index type.
REQ-033 Flag register and condition evaluation SHALL form one sub-module, wb_flag_cond; register array and counter remain in wb_regfile.

Verification
REQ-034 Reset: drive writes, pulse rst_n=0 mid-cycle -> all outputs 0 immediately, wb_cnt=0.
REQ-035 Write/read: write R2=8'hA5 then R1=8'h3C; ra_sel=2, rb_sel=1 -> ra_data=A5, rb_data=3C; wb_cnt=2.
REQ-036 Flags/branch: wb_valid=1, flag_we=1, cf_in=1, zf_in=0; next cycle cond=01 -> take=1 one cycle later; cond=10 -> take=0; cond=11 -> 0.
REQ-037 Qualification: wb_we=1, flag_we=1, wb_valid=0, data 8'hFF -> registers, flags, wb_cnt unchanged.
REQ-038 Read-during-write: R0=8'h11, write R0=8'h22 with ra_sel=0 -> ra_data=22 with WB_BYPASS_EN, 11 without; both 22 after edge.
REQ-039 Wrap: 256 accepted writes from reset -> wb_cnt returns to 8'h00; flag-only cycles leave it unchanged.
